// File: rtl/kmc_dmux_seq.sv
// rtl/kmc_dmux_seq.sv - sequenced source/immediate data multiplexor with lane extract and handshaked result
module kmc_dmux_seq #(
    parameter int              NSRC     = 16,
    parameter int              SRCW     = 16,
    parameter int              DW       = 8,
    parameter int              LAT      = 2,
    parameter logic [NSRC-1:0] SLOWMASK = '0,
    localparam int             SELW     = $clog2(NSRC) + 1,
    localparam int             NLANE    = SRCW / DW,
    localparam int             LANEW    = (NLANE > 1) ? $clog2(NLANE) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NSRC*SRCW-1:0] srcData,
    input  logic                 req,
    input  logic                 immSel,
    input  logic [SELW-1:0]      sel,
    input  logic [LANEW-1:0]     lane,
    input  logic [DW-1:0]        imm,
    input  logic                 ack,
    input  logic                 errClr,
    output logic                 ready,
    output logic                 valid,
    output logic [DW-1:0]        data,
    output logic                 err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

    state_t           r_state, w_state_nx;
    logic [SELW-1:0]  r_sel, w_msel;
    logic [LANEW-1:0] r_lane, w_mlane;
    logic [3:0]       r_cnt, w_cnt_nx;
    logic [DW-1:0]    r_data, w_data_nx, w_lane_data;
    logic [SRCW-1:0]  w_word;
    logic             r_valid, w_valid_nx;
    logic             r_err, w_err_set;
    logic             w_in_range, w_slow, w_capture;

    // In IDLE the live request picks the source; in WAIT the captured one does.
    assign w_msel  = (r_state == S_IDLE) ? sel  : r_sel;
    assign w_mlane = (r_state == S_IDLE) ? lane : r_lane;

    always_comb begin
        w_word     = '0;
        w_in_range = 1'b0;
        w_slow     = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (w_msel == SELW'(i)) begin
                w_word     = srcData[i*SRCW +: SRCW];
                w_in_range = 1'b1;
                w_slow     = SLOWMASK[i];
            end
        end
    end

    always_comb begin
        w_lane_data = '0;
        for (int j = 0; j < NLANE; j++) begin
            if (w_mlane == LANEW'(j))
                w_lane_data = w_word[j*DW +: DW];
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_data_nx  = r_data;
        w_valid_nx = r_valid;
        w_err_set  = 1'b0;
        w_capture  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_capture = 1'b1;
                    if (immSel) begin
                        w_data_nx  = imm;
                        w_valid_nx = 1'b1;
                        w_state_nx = S_HOLD;
                    end else if (!w_in_range) begin
                        w_data_nx  = '0;
                        w_valid_nx = 1'b1;
                        w_err_set  = 1'b1;
                        w_state_nx = S_HOLD;
                    end else if (w_slow) begin
                        w_cnt_nx   = 4'(LAT - 1);
                        w_state_nx = S_WAIT;
                    end else begin
                        w_data_nx  = w_lane_data;
                        w_valid_nx = 1'b1;
                        w_state_nx = S_HOLD;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_data_nx  = w_lane_data;
                    w_valid_nx = 1'b1;
                    w_state_nx = S_HOLD;
                end else begin
                    w_cnt_nx = r_cnt - 4'd1;
                end
            end
            S_HOLD: begin
                if (ack) begin
                    w_valid_nx = 1'b0;
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_sel   <= '0;
            r_lane  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_data  <= w_data_nx;
            r_valid <= w_valid_nx;
            if (w_capture) begin
                r_sel  <= sel;
                r_lane <= lane;
            end
            // A new out-of-range accept outranks a simultaneous clear.
            if (w_err_set)
                r_err <= 1'b1;
            else if (errClr)
                r_err <= 1'b0;
        end
    end

    assign ready = (r_state == S_IDLE);
    assign valid = r_valid;
    assign data  = r_data;
    assign err   = r_err;

endmodule

// File: tb/tb_kmc_dmux_seq.sv
// tb/tb_kmc_dmux_seq.sv - directed self-checking bench for kmc_dmux_seq
module tb_kmc_dmux_seq;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [255:0]   srcData;
    logic           req, immSel, ack, errClr;
    logic [4:0]     sel;
    logic [0:0]     lane;
    logic [7:0]     imm;
    logic           ready, valid, err;
    logic [7:0]     data;
    int             checks = 0;
    int             failures = 0;

    kmc_dmux_seq #(
        .NSRC(16), .SRCW(16), .DW(8), .LAT(2), .SLOWMASK(16'h000C)
    ) dut (
        .clk(clk), .rst_n(rst_n), .srcData(srcData), .req(req), .immSel(immSel),
        .sel(sel), .lane(lane), .imm(imm), .ack(ack), .errClr(errClr),
        .ready(ready), .valid(valid), .data(data), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic is_imm, input logic [4:0] s, input logic l, input logic [7:0] im);
        req = 1'b1; immSel = is_imm; sel = s; lane = l; imm = im;
        tick();
        req = 1'b0; immSel = 1'b0;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; srcData = '0; req = 0; immSel = 0; ack = 0; errClr = 0;
        sel = '0; lane = '0; imm = '0;
        tick(); tick();
        chk("rst_ready", ready, 1); chk("rst_valid", valid, 0);
        chk("rst_data", data, 0);   chk("rst_err", err, 0);
        rst_n = 1'b1;
        tick();

        // fast source, both lanes
        srcData[5*16 +: 16] = 16'hA55A;
        do_req(0, 5'd5, 1'b1, 8'h00);
        chk("fast_l1_valid", valid, 1); chk("fast_l1_data", data, 8'hA5); chk("fast_l1_ready", ready, 0);
        do_ack();
        chk("fast_l1_ready_after_ack", ready, 1); chk("fast_l1_valid_after_ack", valid, 0);
        chk("fast_l1_data_retained", data, 8'hA5);
        do_req(0, 5'd5, 1'b0, 8'h00);
        chk("fast_l0_valid", valid, 1); chk("fast_l0_data", data, 8'h5A);
        do_ack();

        // immediate ignores out-of-range sel
        do_req(1, 5'd31, 1'b0, 8'h3C);
        chk("imm_valid", valid, 1); chk("imm_data", data, 8'h3C); chk("imm_err", err, 0);
        do_ack();

        // out of range and err set/clear priority
        do_req(0, 5'd16, 1'b1, 8'h00);
        chk("oor_valid", valid, 1); chk("oor_data", data, 8'h00); chk("oor_err", err, 1);
        do_ack();
        errClr = 1'b1;
        do_req(0, 5'd17, 1'b0, 8'h00);
        errClr = 1'b0;
        chk("oor_setwins_err", err, 1);
        do_ack();
        chk("err_sticky", err, 1);
        errClr = 1'b1;
        tick();
        errClr = 1'b0;
        chk("errclr_err", err, 0);

        // async reset mid-WAIT with data and err nonzero beforehand
        do_req(0, 5'd20, 1'b0, 8'h00);
        do_ack();
        do_req(1, 5'd0, 1'b0, 8'h3C);
        do_ack();
        chk("pre_rst_err", err, 1); chk("pre_rst_data", data, 8'h3C);
        srcData[2*16 +: 16] = 16'h7788;
        do_req(0, 5'd2, 1'b0, 8'h00);
        chk("slow2_wait_ready", ready, 0); chk("slow2_wait_valid", valid, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", valid, 0); chk("midrst_ready", ready, 1);
        chk("midrst_data", data, 0);   chk("midrst_err", err, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("postrst_valid", valid, 0);

        // slow source sampled LAT cycles after accept
        srcData[3*16 +: 16] = 16'h0011;
        do_req(0, 5'd3, 1'b0, 8'h00);
        chk("slow_t1_valid", valid, 0);
        srcData[3*16 +: 16] = 16'h0022;
        tick();
        chk("slow_t2_valid", valid, 0);
        tick();
        chk("slow_t3_valid", valid, 1); chk("slow_t3_data", data, 8'h22);
        srcData[3*16 +: 16] = 16'h0033;
        tick();
        chk("slow_hold_data", data, 8'h22);
        do_ack();

        // HOLD stability and ignored req pulses
        do_req(0, 5'd5, 1'b1, 8'h00);
        for (int k = 0; k < 10; k++) begin
            req = k[0]; sel = 5'd3; lane = 1'b0;
            tick();
            chk("hold_valid", valid, 1); chk("hold_data", data, 8'hA5); chk("hold_ready", ready, 0);
        end
        req = 1'b0;
        do_ack();
        chk("hs_ack_valid", valid, 0); chk("hs_ack_ready", ready, 1);
        tick(); tick(); tick(); tick();
        chk("hs_no_spurious_valid", valid, 0); chk("hs_no_spurious_ready", ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
